// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// the elaboration-time width legality check.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 32;

  function automatic bit width_legal(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/serial_add_sub_fa_cell.sv
// Single-bit combinational full adder; the serial datapath feeds it one
// operand bit pair per clock together with the registered carry.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock. Subtraction is
// A + ~B + 1, with the +1 injected as the initial carry.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("serial_add_sub: WIDTH must be in 1..32");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] acc_shift;
  logic             last_bit;

  fa_cell u_fa (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_cout)
  );

  // The new sum bit enters at the MSB so that after WIDTH shifts the LSB lines up.
  if (WIDTH == 1) begin : g_acc_w1
    assign acc_shift = fa_s;
  end else begin : g_acc_wn
    assign acc_shift = {fa_s, acc_q[WIDTH-1:1]};
  end

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sr_d  = op_a;
          b_sr_d  = sub ? ~op_b : op_b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_cout;
        acc_d   = acc_shift;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          // carry_q here is the carry into the MSB, needed for signed overflow.
          sum_d   = acc_shift;
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and random checks of serial_add_sub at WIDTH 1, 8 and 32.
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op_a_t, op_b_t;
  logic        sub_t, out_ready_t;
  logic        iv1, iv8, iv32;

  logic        ir1, ov1, s1, c1, o1;
  logic        ir8, ov8, c8, o8;
  logic [7:0]  s8;
  logic        ir32, ov32, c32, o32;
  logic [31:0] s32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .op_a(op_a_t[0:0]), .op_b(op_b_t[0:0]), .sub(sub_t),
    .out_valid(ov1), .out_ready(out_ready_t), .sum(s1),
    .carry_out(c1), .overflow(o1));

  serial_add_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .op_a(op_a_t[7:0]), .op_b(op_b_t[7:0]), .sub(sub_t),
    .out_valid(ov8), .out_ready(out_ready_t), .sum(s8),
    .carry_out(c8), .overflow(o8));

  serial_add_sub #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .op_a(op_a_t), .op_b(op_b_t), .sub(sub_t),
    .out_valid(ov32), .out_ready(out_ready_t), .sum(s32),
    .carry_out(c32), .overflow(o32));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] esum;
    logic       ecout;
    logic       eovf;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  function automatic logic ov_of(input int w);
    return (w == 1) ? ov1 : (w == 8) ? ov8 : ov32;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on the instance of width w and collect its result.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic br,
                        output logic [31:0] rs, output logic rc, output logic ro,
                        output int lat);
    op_a_t = a; op_b_t = b; sub_t = s; out_ready_t = br;
    iv1 = (w == 1); iv8 = (w == 8); iv32 = (w == 32);
    step();
    iv1 = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
    lat = 0;
    while (!ov_of(w) && lat < 200) begin
      step();
      lat++;
    end
    rs = (w == 1) ? {31'b0, s1} : (w == 8) ? {24'b0, s8} : s32;
    rc = (w == 1) ? c1 : (w == 8) ? c8 : c32;
    ro = (w == 1) ? o1 : (w == 8) ? o8 : o32;
    out_ready_t = 1'b1;
    step();
    out_ready_t = br;
  endtask

  // Arithmetic reference: whole-word addition, carry into MSB from the low part.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic s, output logic [31:0] es, output logic ec,
                       output logic eo);
    logic [63:0] mask, lom, bb, t, lo;
    mask = (64'd1 << w) - 64'd1;
    lom  = (64'd1 << (w - 1)) - 64'd1;
    bb   = s ? (~{32'd0, b} & mask) : {32'd0, b};
    t    = {32'd0, a} + bb + {63'd0, s};
    lo   = ({32'd0, a} & lom) + (bb & lom) + {63'd0, s};
    es   = t[31:0] & mask[31:0];
    ec   = t[w];
    eo   = lo[w-1] ^ t[w];
  endtask

  initial begin
    vec_t        vecs[7];
    logic [31:0] rs, es;
    logic        rc, ro, ec, eo;
    int          lat;
    int          widths[3];

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    widths  = '{1, 8, 32};

    rst = 1'b1; iv1 = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
    op_a_t = '0; op_b_t = '0; sub_t = 1'b0; out_ready_t = 1'b0;
    step(); step();
    rst = 1'b0;

    check("rst in_ready", {31'b0, ir8}, 32'd1);
    check("rst out_valid", {31'b0, ov8}, 32'd0);
    check("rst sum", {24'b0, s8}, 32'd0);
    check("rst carry", {31'b0, c8}, 32'd0);
    check("rst ovf", {31'b0, o8}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(8, {24'b0, vecs[i].a}, {24'b0, vecs[i].b}, vecs[i].s, 1'b0, rs, rc, ro, lat);
      $display("vec %0d: a=%02h b=%02h sub=%0d -> sum=%02h c=%0d v=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].s, rs[7:0], rc, ro, lat);
      check("vec latency", lat, 32'd8);
      check("vec sum", rs, {24'b0, vecs[i].esum});
      check("vec carry", {31'b0, rc}, {31'b0, vecs[i].ecout});
      check("vec ovf", {31'b0, ro}, {31'b0, vecs[i].eovf});
    end

    // Backpressure, operand change during RUN, and no same-cycle re-accept.
    op_a_t = 32'h12; op_b_t = 32'h34; sub_t = 1'b0; out_ready_t = 1'b0; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    step(); step();
    op_a_t = 32'hFF; iv8 = 1'b1;
    lat = 2;
    while (!ov8 && lat < 200) begin step(); lat++; end
    iv8 = 1'b0;
    check("bp latency", lat, 32'd8);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp out_valid held", {31'b0, ov8}, 32'd1);
      check("bp sum held", {24'b0, s8}, 32'h46);
      check("bp in_ready low", {31'b0, ir8}, 32'd0);
    end
    op_a_t = 32'hFF; op_b_t = 32'h01; iv8 = 1'b1; out_ready_t = 1'b1;
    step();
    out_ready_t = 1'b0;
    check("handshake out_valid", {31'b0, ov8}, 32'd0);
    check("no same-cycle accept", {31'b0, ir8}, 32'd1);
    step();
    iv8 = 1'b0;
    check("next accept", {31'b0, ir8}, 32'd0);
    lat = 0;
    while (!ov8 && lat < 200) begin step(); lat++; end
    check("reaccept latency", lat, 32'd8);
    check("reaccept sum", {24'b0, s8}, 32'h00);
    check("reaccept carry", {31'b0, c8}, 32'd1);
    out_ready_t = 1'b1;
    step();
    out_ready_t = 1'b0;

    // Reset mid-RUN; leave a nonzero result first so the clear is observable.
    run_op(8, 32'h0F, 32'h01, 1'b0, 1'b0, rs, rc, ro, lat);
    check("pre-reset sum", rs, 32'h10);
    op_a_t = 32'h33; op_b_t = 32'h44; sub_t = 1'b0; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun rst in_ready", {31'b0, ir8}, 32'd1);
    check("midrun rst out_valid", {31'b0, ov8}, 32'd0);
    check("midrun rst sum", {24'b0, s8}, 32'd0);
    run_op(8, 32'h01, 32'h01, 1'b0, 1'b0, rs, rc, ro, lat);
    check("post-rst sum", rs, 32'h02);
    check("post-rst latency", lat, 32'd8);

    run_op(1, 32'h1, 32'h1, 1'b0, 1'b0, rs, rc, ro, lat);
    check("w1 latency", lat, 32'd1);
    check("w1 sum", rs, 32'd0);
    check("w1 carry", {31'b0, rc}, 32'd1);
    check("w1 ovf", {31'b0, ro}, 32'd1);

    // Random back-to-back operations against the arithmetic reference.
    foreach (widths[wi]) begin
      for (int n = 0; n < 12; n++) begin
        logic [31:0] ra, rb;
        logic        rsub;
        ra   = $urandom;
        rb   = $urandom;
        rsub = 1'($urandom_range(0, 1));
        if (widths[wi] < 32) begin
          ra = ra & ((32'd1 << widths[wi]) - 32'd1);
          rb = rb & ((32'd1 << widths[wi]) - 32'd1);
        end
        model(widths[wi], ra, rb, rsub, es, ec, eo);
        run_op(widths[wi], ra, rb, rsub, 1'b1, rs, rc, ro, lat);
        $display("rnd w=%0d a=%0h b=%0h sub=%0d -> sum=%0h c=%0d v=%0d",
                 widths[wi], ra, rb, rsub, rs, rc, ro);
        check("rnd latency", lat, widths[wi]);
        check("rnd sum", rs, es);
        check("rnd flags", {30'b0, rc, ro}, {30'b0, ec, eo});
      end
      out_ready_t = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
